// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module  : control_unit
// Brief   : SAMAB main decoder; opcode -> registered datapath control strobes.
// Revision: 1.0
// ============================================================================
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  output logic       branch,
  output logic       regdst,
  output logic       alusrc,
  output logic       regwrite,
  output logic       memread,
  output logic       memreg,
  output logic       memweite,
  output logic [2:0] aluop
);

  localparam logic [2:0] C_ALU_ADD = 3'b000;
  localparam logic [2:0] C_ALU_SUB = 3'b001;
  localparam logic [2:0] C_ALU_AND = 3'b010;
  localparam logic [2:0] C_ALU_OR  = 3'b011;
  localparam logic [2:0] C_ALU_XOR = 3'b100;
  localparam logic [2:0] C_ALU_SLT = 3'b101;
  localparam logic [2:0] C_ALU_SLL = 3'b110;
  localparam logic [2:0] C_ALU_SRL = 3'b111;

  // Packed as {branch, regdst, alusrc, regwrite, memread, memreg, memweite, aluop}
  logic [9:0] ctrl_d;
  logic [9:0] ctrl_q;

  // Unmatched opcodes (including X/Z) fall to the default and decode as NOP.
  always_comb begin
    ctrl_d = 10'b0;
    case (opcode)
      4'd0:  ctrl_d = {7'b0101000, C_ALU_ADD};
      4'd1:  ctrl_d = {7'b0101000, C_ALU_SUB};
      4'd2:  ctrl_d = {7'b0101000, C_ALU_AND};
      4'd3:  ctrl_d = {7'b0101000, C_ALU_OR};
      4'd4:  ctrl_d = {7'b0101000, C_ALU_XOR};
      4'd5:  ctrl_d = {7'b0101000, C_ALU_SLT};
      4'd6:  ctrl_d = {7'b0011000, C_ALU_ADD};
      4'd7:  ctrl_d = {7'b0011000, C_ALU_AND};
      4'd8:  ctrl_d = {7'b0011110, C_ALU_ADD};
      4'd9:  ctrl_d = {7'b0010001, C_ALU_ADD};
      4'd10: ctrl_d = {7'b1000000, C_ALU_SUB};
      4'd11: ctrl_d = {7'b0011000, C_ALU_OR};
      4'd12: ctrl_d = {7'b0011000, C_ALU_SLT};
      4'd13: ctrl_d = {7'b0111000, C_ALU_SLL};
      4'd14: ctrl_d = {7'b0111000, C_ALU_SRL};
      default: ctrl_d = 10'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= 10'b0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign branch   = ctrl_q[9];
  assign regdst   = ctrl_q[8];
  assign alusrc   = ctrl_q[7];
  assign regwrite = ctrl_q[6];
  assign memread  = ctrl_q[5];
  assign memreg   = ctrl_q[4];
  assign memweite = ctrl_q[3];
  assign aluop    = ctrl_q[2:0];

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_control_unit
// Brief   : Self-checking bench for control_unit against a table-rule model.
// Revision: 1.0
// ============================================================================
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] opcode;
  logic       branch, regdst, alusrc, regwrite, memread, memreg, memweite;
  logic [2:0] aluop;

  int n_checks = 0;
  int n_errors = 0;

  control_unit u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .branch   (branch),
    .regdst   (regdst),
    .alusrc   (alusrc),
    .regwrite (regwrite),
    .memread  (memread),
    .memreg   (memreg),
    .memweite (memweite),
    .aluop    (aluop)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  logic [9:0] w_obs;
  assign w_obs = {branch, regdst, alusrc, regwrite, memread, memreg, memweite, aluop};

  logic [2:0] alu_tab [16];
  initial begin
    alu_tab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd2,
                3'd0, 3'd0, 3'd1, 3'd3, 3'd5, 3'd6, 3'd7, 3'd0};
  end

  // Reference: each strobe stated as the set of opcodes that assert it.
  function automatic logic [9:0] ref_decode(input logic [3:0] op);
    logic br, rd, as, rw, mr, mg, mw;
    br = (op == 4'd10);
    rd = (op <= 4'd5) || (op == 4'd13) || (op == 4'd14);
    as = (op >= 4'd6 && op <= 4'd9) || (op >= 4'd11 && op <= 4'd14);
    rw = (op <= 4'd8) || (op >= 4'd11 && op <= 4'd14);
    mr = (op == 4'd8);
    mg = (op == 4'd8);
    mw = (op == 4'd9);
    return {br, rd, as, rw, mr, mg, mw, alu_tab[op]};
  endfunction

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_invariants(input string tag);
    chk({tag, "_inv_mem"}, {9'b0, memread & memweite}, 10'b0);
    chk({tag, "_inv_rw"},  {9'b0, regwrite & (memweite | branch)}, 10'b0);
    chk({tag, "_inv_mg"},  {9'b0, memreg & ~memread}, 10'b0);
  endtask

  // Drive opcode mid-cycle, then look just after the next rising edge.
  task automatic step(input logic [3:0] op);
    @(negedge clk);
    opcode = op;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 4'd8;
    #1;
    chk("reset_async", w_obs, 10'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", w_obs, 10'b0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_release_lw", w_obs, {7'b0011110, 3'b000});

    // Asynchronous reset in the middle of a cycle.
    #10;
    rst_n = 1'b0;
    #1;
    chk("reset_midcycle", w_obs, 10'b0);
    @(negedge clk);
    rst_n = 1'b1;

    step(4'd0);
    chk("add", w_obs, {7'b0101000, 3'b000});
    step(4'd1);
    chk("sub", w_obs, {7'b0101000, 3'b001});

    // Latency: mid-cycle opcode change must not reach the outputs.
    @(negedge clk);
    opcode = 4'd8;
    #10;
    chk("latency_hold_sub", w_obs, {7'b0101000, 3'b001});
    @(posedge clk);
    #1;
    chk("latency_lw", w_obs, {7'b0011110, 3'b000});

    step(4'd9);
    chk("sw", w_obs, {7'b0010001, 3'b000});
    step(4'd10);
    chk("beq", w_obs, {7'b1000000, 3'b001});
    step(4'd15);
    chk("nop", w_obs, 10'b0);

    for (int i = 0; i < 16; i++) begin
      step(4'(i));
      chk($sformatf("sweep_op%0d", i), w_obs, ref_decode(4'(i)));
      check_invariants($sformatf("sweep_op%0d", i));
    end

    for (int i = 0; i < 200; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      step(op);
      chk($sformatf("rand%0d_op%0d", i, op), w_obs, ref_decode(op));
      check_invariants($sformatf("rand%0d", i));
      if ($urandom_range(0, 31) == 0) begin
        #5;
        rst_n = 1'b0;
        #1;
        chk($sformatf("rand%0d_rst", i), w_obs, 10'b0);
        @(posedge clk);
        #1;
        chk($sformatf("rand%0d_rst_hold", i), w_obs, 10'b0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
